// File: rtl/cgra_pe_param.sv
// Parametrised CGRA processing element: operand crossbars, ALU, scratch MEM, registered output,
// and a serial config chain. Optional CONST operand field enabled by macro PE_CONST_OPERAND_EN.
module cgra_pe_param #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        out0
);

`ifdef PE_CONST_OPERAND_EN
  localparam int HAS_CONST = 1;
`else
  localparam int HAS_CONST = 0;
`endif

  localparam int AW       = $clog2(DEPTH);
  localparam int NSRC     = NUM_IN + 2 + HAS_CONST;
  localparam int SW       = $clog2(NSRC);
  localparam int LW       = $clog2(WIDTH);
  localparam int CFG_W    = 7 + 4 * SW + HAS_CONST * WIDTH;
  localparam int OFS_A    = 4;
  localparam int OFS_B    = 4 + SW;
  localparam int OFS_ADDR = 4 + 2 * SW;
  localparam int OFS_WD   = 4 + 3 * SW;
  localparam int OFS_MM   = 4 + 4 * SW;
  localparam int OFS_OS   = 6 + 4 * SW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_LTU  = 4'd8;
  localparam logic [3:0] OP_EQ   = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  logic [CFG_W-1:0] cfg_r;
  logic [WIDTH-1:0] alu_q_r;
  logic [WIDTH-1:0] mem_q_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [3:0]       alu_op_s;
  logic [SW-1:0]    sel_a_s;
  logic [SW-1:0]    sel_b_s;
  logic [SW-1:0]    sel_addr_s;
  logic [SW-1:0]    sel_wdata_s;
  logic [1:0]       mem_mode_s;
  logic             out_sel_s;
  logic [WIDTH-1:0] const_val_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] wdata_s;
  logic [AW-1:0]    mem_addr_s;
  logic [WIDTH-1:0] alu_s;

  assign alu_op_s    = cfg_r[3:0];
  assign sel_a_s     = cfg_r[OFS_A +: SW];
  assign sel_b_s     = cfg_r[OFS_B +: SW];
  assign sel_addr_s  = cfg_r[OFS_ADDR +: SW];
  assign sel_wdata_s = cfg_r[OFS_WD +: SW];
  assign mem_mode_s  = cfg_r[OFS_MM +: 2];
  assign out_sel_s   = cfg_r[OFS_OS];

`ifdef PE_CONST_OPERAND_EN
  assign const_val_s = cfg_r[CFG_W-1 -: WIDTH];
`else
  assign const_val_s = {WIDTH{1'b0}};
`endif

  // Crossbar: inputs, then ALU/MEM feedback, then CONST; anything else reads as zero.
  function automatic logic [WIDTH-1:0] pick(
    input logic [SW-1:0]           sel,
    input logic [NUM_IN*WIDTH-1:0] ins,
    input logic [WIDTH-1:0]        aq,
    input logic [WIDTH-1:0]        mq,
    input logic [WIDTH-1:0]        cv
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) r = ins[i*WIDTH +: WIDTH];
      else                r = r;
    end
    if (int'(sel) == NUM_IN)                            r = aq;
    else if (int'(sel) == NUM_IN + 1)                   r = mq;
    else if ((HAS_CONST != 0) && (int'(sel) == NUM_IN + 2)) r = cv;
    else                                                r = r;
    return r;
  endfunction

  function automatic logic [AW-1:0] low_addr(input logic [WIDTH-1:0] v);
    return v[AW-1:0];
  endfunction

  // Operand selection for ALU and memory port
  always_comb begin
    a_s        = pick(sel_a_s,     in_data, alu_q_r, mem_q_r, const_val_s);
    b_s        = pick(sel_b_s,     in_data, alu_q_r, mem_q_r, const_val_s);
    wdata_s    = pick(sel_wdata_s, in_data, alu_q_r, mem_q_r, const_val_s);
    mem_addr_s = low_addr(pick(sel_addr_s, in_data, alu_q_r, mem_q_r, const_val_s));
  end

  // ALU function
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (alu_op_s)
      OP_ADD:  alu_s = a_s + b_s;
      OP_SUB:  alu_s = a_s - b_s;
      OP_MUL:  alu_s = a_s * b_s;
      OP_AND:  alu_s = a_s & b_s;
      OP_OR:   alu_s = a_s | b_s;
      OP_XOR:  alu_s = a_s ^ b_s;
      OP_SHL:  alu_s = a_s << b_s[LW-1:0];
      OP_SHR:  alu_s = a_s >> b_s[LW-1:0];
      OP_LTU:  alu_s = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_EQ:   alu_s = {{(WIDTH-1){1'b0}}, (a_s == b_s)};
      OP_PASS: alu_s = a_s;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // Config chain and datapath registers; config shifting freezes the datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_r   <= {CFG_W{1'b0}};
      alu_q_r <= {WIDTH{1'b0}};
      mem_q_r <= {WIDTH{1'b0}};
      out_r   <= {WIDTH{1'b0}};
    end else if (config_en) begin
      cfg_r <= {cfg_r[CFG_W-2:0], config_in};
    end else begin
      alu_q_r <= alu_s;
      if (mem_mode_s[0]) mem_q_r <= mem_r[mem_addr_s];
      out_r <= out_sel_s ? mem_q_r : alu_q_r;
    end
  end

  // Scratch memory write; contents survive reset, but a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (!reset && !config_en && mem_mode_s[1]) begin
      mem_r[mem_addr_s] <= wdata_s;
    end
  end

  assign config_out = cfg_r[CFG_W-1];
  assign out0       = out_r;

endmodule

// File: tb/tb_cgra_pe_param.sv
// Directed self-checking bench for cgra_pe_param (default parameters, NUM_IN=2).
module tb_cgra_pe_param;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 2;
  localparam int DEPTH  = 16;

`ifdef PE_CONST_OPERAND_EN
  localparam int HAS_CONST = 1;
`else
  localparam int HAS_CONST = 0;
`endif
  localparam int NSRC   = NUM_IN + 2 + HAS_CONST;
  localparam int SW     = $clog2(NSRC);
  localparam int CFG_W  = 7 + 4 * SW + HAS_CONST * WIDTH;
  localparam int OFS_MM = 4 + 4 * SW;
  localparam int OFS_OS = 6 + 4 * SW;

  logic                    clk;
  logic                    reset;
  logic                    config_en;
  logic                    config_in;
  logic                    config_out;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [WIDTH-1:0]        out0;

  int checks   = 0;
  int failures = 0;

  cgra_pe_param #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in_data    (in_data),
    .out0       (out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_data = {b, a};
  endtask

  function automatic logic [CFG_W-1:0] cfg_word(input int op, input int sa, input int sb,
                                                 input int sad, input int swd, input int mm,
                                                 input int os, input logic [WIDTH-1:0] cv);
    logic [CFG_W-1:0] w;
    logic [31:0]      t;
    w = '0;
    t = op;  w[3:0]             = t[3:0];
    t = sa;  w[4 +: SW]         = t[SW-1:0];
    t = sb;  w[4 + SW +: SW]    = t[SW-1:0];
    t = sad; w[4 + 2*SW +: SW]  = t[SW-1:0];
    t = swd; w[4 + 3*SW +: SW]  = t[SW-1:0];
    t = mm;  w[OFS_MM +: 2]     = t[1:0];
    t = os;  w[OFS_OS]          = t[0];
`ifdef PE_CONST_OPERAND_EN
    w[OFS_OS + 1 +: WIDTH] = cv;
`else
    if (cv != '0) w = w;
`endif
    return w;
  endfunction

  // Shift a config word in MSB first so that it lands aligned in the chain.
  task automatic load_cfg(input logic [CFG_W-1:0] w);
    config_en = 1'b1;
    for (int i = CFG_W - 1; i >= 0; i--) begin
      config_in = w[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  typedef struct {
    int               op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$];
  logic     bits[$];

  initial begin
    reset     = 1'b1;
    config_en = 1'b0;
    config_in = 1'b0;
    in_data   = '0;
    #2;
    check_val("reset_out0", out0, 32'h0);
    check_val("reset_cfg_out", {31'h0, config_out}, 32'h0);
    #5;
    reset = 1'b0;
    #1;

    // Config chain: CFG_W bits of 1010.. then CFG_W zeros.
    for (int k = 0; k < 2 * CFG_W + 1; k++) bits.push_back((k < CFG_W) ? ((k % 2) == 0) : 1'b0);
    config_en = 1'b1;
    for (int k = 0; k < 2 * CFG_W; k++) begin
      config_in = bits[k];
      tick();
      if (k >= CFG_W - 1) check_val($sformatf("shift_%0d", k), {31'h0, config_out}, {31'h0, bits[k - CFG_W + 1]});
    end
    config_en = 1'b0;
    config_in = 1'b0;
    check_val("shift_frozen_out0", out0, 32'h0);

    // ADD with two-cycle latency
    set_in(32'd5, 32'd7);
    load_cfg(cfg_word(0, 0, 1, 0, 0, 0, 0, '0));
    tick();
    check_val("add_lat1", out0, 32'h0);
    tick();
    check_val("add", out0, 32'd12);

    load_cfg(cfg_word(1, 0, 1, 0, 0, 0, 0, '0));
    set_in(32'd3, 32'd5);
    tick(); tick();
    check_val("sub", out0, 32'hFFFF_FFFE);

    vecs.push_back('{0,  32'hFFFF_FFFF, 32'd2,        32'd1});
    vecs.push_back('{2,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001});
    vecs.push_back('{3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000});
    vecs.push_back('{4,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF});
    vecs.push_back('{5,  32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0});
    vecs.push_back('{6,  32'd1,        32'd36,       32'h0000_0010});
    vecs.push_back('{7,  32'h8000_0000, 32'd31,       32'd1});
    vecs.push_back('{8,  32'd3,        32'd5,        32'd1});
    vecs.push_back('{8,  32'hFFFF_FFFF, 32'd1,        32'd0});
    vecs.push_back('{9,  32'd7,        32'd7,        32'd1});
    vecs.push_back('{10, 32'h0000_1234, 32'd9,        32'h0000_1234});
    vecs.push_back('{12, 32'd6,        32'd9,        32'd0});
    foreach (vecs[i]) begin
      set_in(vecs[i].a, vecs[i].b);
      load_cfg(cfg_word(vecs[i].op, 0, 1, 0, 0, 0, 0, '0));
      tick(); tick();
      check_val($sformatf("alu_op%0d_%0d", vecs[i].op, i), out0, vecs[i].exp);
    end

    // Accumulator through alu_q feedback
    reset = 1'b1; #1; reset = 1'b0;
    set_in(32'd1, 32'd0);
    load_cfg(cfg_word(0, NUM_IN, 0, 0, 0, 0, 0, '0));
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_val($sformatf("acc_%0d", n), out0, 32'(n - 1));
    end

    // MEM: store, wrapped-address load, swap
    set_in(32'd3, 32'h0000_DEAD);
    load_cfg(cfg_word(0, 0, 0, 0, 1, 2, 0, '0));
    tick();
    set_in(32'd19, 32'h0);
    load_cfg(cfg_word(0, 0, 0, 0, 1, 1, 1, '0));
    tick(); tick();
    check_val("mem_load_wrap", out0, 32'h0000_DEAD);
    set_in(32'd3, 32'h0000_BEEF);
    load_cfg(cfg_word(0, 0, 0, 0, 1, 3, 1, '0));
    tick(); tick();
    check_val("swap_old", out0, 32'h0000_DEAD);
    tick();
    check_val("swap_new", out0, 32'h0000_BEEF);

    // Reset mid-shift
    config_en = 1'b1;
    config_in = 1'b1;
    for (int k = 0; k < CFG_W; k++) tick();
    check_val("pre_reset_cfg_out", {31'h0, config_out}, 32'h1);
    reset = 1'b1;
    #1;
    check_val("rst_shift_out0", out0, 32'h0);
    check_val("rst_shift_cfg_out", {31'h0, config_out}, 32'h0);
    #2;
    reset = 1'b0;
    config_en = 1'b0;
    config_in = 1'b0;
    set_in(32'd21, 32'd99);
    tick(); tick();
    check_val("default_cfg", out0, 32'd42);

    // Reset mid-store
    set_in(32'd5, 32'h0000_1111);
    load_cfg(cfg_word(0, 1, 1, 0, 1, 2, 0, '0));
    tick();
    set_in(32'd5, 32'h0000_2222);
    reset = 1'b1;
    #1;
    check_val("rst_store_out0", out0, 32'h0);
    tick();
    reset = 1'b0;
    load_cfg(cfg_word(0, 0, 0, 0, 0, 1, 1, '0));
    tick(); tick();
    check_val("rst_store_word", out0, 32'h0000_1111);

    // CONST operand (index NUM_IN+2); the plain build has no such selector, so mem_q (zero after reset) stands in
    reset = 1'b1; #1; reset = 1'b0;
    set_in(32'd1, 32'd50);
`ifdef PE_CONST_OPERAND_EN
    load_cfg(cfg_word(0, 0, NUM_IN + 2, 0, 0, 0, 0, 32'd100));
    tick(); tick();
    check_val("const_operand", out0, 32'd101);
`else
    load_cfg(cfg_word(0, 0, NUM_IN + 1, 0, 0, 0, 0, '0));
    tick(); tick();
    check_val("no_const_operand", out0, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
